// File: rtl/hack_data_mem.sv
// rtl/hack_data_mem.sv - Hack CPU data memory: RAM, screen shadow with update FIFO, keyboard register
module hack_data_mem #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic [14:0] data_addr,
  input  logic [15:0] out_m,
  input  logic        write_m,
  output logic [15:0] in_m,
  input  logic [15:0] kbd_code,
  output logic        scr_valid,
  output logic [12:0] scr_addr,
  output logic [15:0] scr_data,
  input  logic        scr_ready,
  output logic        scr_ovf
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);

  logic [15:0] ram    [0:16383];
  logic [15:0] shadow [0:8191];
  logic [12:0] fifo_addr [0:FIFO_DEPTH-1];
  logic [15:0] fifo_data [0:FIFO_DEPTH-1];

  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [15:0]   kbd_reg;
  logic [15:0]   mem_q;
  logic          sel_kbd;
  logic [15:0]   rd_data;

  logic is_ram, is_scr, is_kbd;
  logic full, pop, scr_wr, push;

  assign is_ram = ~data_addr[14];
  assign is_scr = (data_addr[14:13] == 2'b10);
  assign is_kbd = (data_addr == 15'h6000);

  assign full   = (count == FULL_COUNT);
  assign pop    = scr_valid & scr_ready;
  assign scr_wr = write_m & is_scr;
  // A pop on the same edge frees a slot, so a full FIFO still accepts the push.
  assign push   = scr_wr & (~full | pop);

  assign scr_valid = (count != '0);
  assign scr_addr  = fifo_addr[rd_ptr];
  assign scr_data  = fifo_data[rd_ptr];

  // Keyboard reads come from the register loaded on the same edge as the address.
  assign in_m = sel_kbd ? kbd_reg : mem_q;

  always_ff @(posedge clk) begin
    if (write_m && is_ram) ram[data_addr[13:0]] <= out_m;
    if (scr_wr) shadow[data_addr[12:0]] <= out_m;
    if (push) begin
      fifo_addr[wr_ptr] <= data_addr[12:0];
      fifo_data[wr_ptr] <= out_m;
    end
  end

  always_comb begin
    rd_data = '0;
    if (is_ram) rd_data = write_m ? out_m : ram[data_addr[13:0]];
    else if (is_scr) rd_data = write_m ? out_m : shadow[data_addr[12:0]];
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      mem_q   <= '0;
      sel_kbd <= 1'b0;
      kbd_reg <= '0;
    end else begin
      mem_q   <= rd_data;
      sel_kbd <= is_kbd;
      kbd_reg <= kbd_code;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      scr_ovf <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (scr_wr && full && !pop) scr_ovf <= 1'b1;
    end
  end

endmodule

// File: tb/tb_hack_data_mem.sv
// tb/tb_hack_data_mem.sv - self-checking bench for hack_data_mem against a queue/array reference model
module tb_hack_data_mem;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        resetN = 1'b0;
  logic [14:0] data_addr = '0;
  logic [15:0] out_m = '0;
  logic        write_m = 1'b0;
  logic [15:0] in_m;
  logic [15:0] kbd_code = '0;
  logic        scr_valid;
  logic [12:0] scr_addr;
  logic [15:0] scr_data;
  logic        scr_ready = 1'b0;
  logic        scr_ovf;

  int n_cmp = 0;
  int n_fail = 0;

  logic [15:0] ram_m [int];
  logic [15:0] scr_m [int];
  logic [28:0] q [$];
  logic        ovf_m = 1'b0;
  logic [15:0] exp_in;
  logic        exp_known;

  hack_data_mem #(.FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .resetN(resetN), .data_addr(data_addr), .out_m(out_m),
    .write_m(write_m), .in_m(in_m), .kbd_code(kbd_code), .scr_valid(scr_valid),
    .scr_addr(scr_addr), .scr_data(scr_data), .scr_ready(scr_ready), .scr_ovf(scr_ovf)
  );

  always #5 clk = ~clk;

  // Applies one cycle of inputs, predicts in_m from the address map, and advances the model.
  task automatic drive_cycle(input logic [14:0] a, input logic [15:0] d, input logic w,
                             input logic [15:0] k, input logic r);
    logic [14:0] off;
    logic [28:0] tmp;
    data_addr = a; out_m = d; write_m = w; kbd_code = k; scr_ready = r;
    exp_known = 1'b1;
    exp_in = 16'h0000;
    if (a < 15'h4000) begin
      if (w) exp_in = d;
      else if (ram_m.exists(int'(a))) exp_in = ram_m[int'(a)];
      else exp_known = 1'b0;
    end else if (a < 15'h6000) begin
      if (w) exp_in = d;
      else if (scr_m.exists(int'(a))) exp_in = scr_m[int'(a)];
      else exp_known = 1'b0;
    end else if (a == 15'h6000) begin
      exp_in = k;
    end
    if (q.size() != 0 && r) tmp = q.pop_front();
    if (w && a < 15'h4000) ram_m[int'(a)] = d;
    if (w && a >= 15'h4000 && a < 15'h6000) begin
      scr_m[int'(a)] = d;
      off = a - 15'h4000;
      if (q.size() < DEPTH) q.push_back({off[12:0], d});
      else ovf_m = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    resetN = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    n_cmp++; if (in_m !== 16'h0) begin n_fail++; $display("FAIL reset_in_m: got %h expected 0000", in_m); end
    n_cmp++; if (scr_valid !== 1'b0) begin n_fail++; $display("FAIL reset_scr_valid: got %b expected 0", scr_valid); end
    n_cmp++; if (scr_ovf !== 1'b0) begin n_fail++; $display("FAIL reset_scr_ovf: got %b expected 0", scr_ovf); end
    resetN = 1'b1;
    #2;
    n_cmp++; if (in_m !== 16'h0 || scr_valid !== 1'b0) begin n_fail++; $display("FAIL reset_release_hold: got in_m=%h valid=%b expected 0000/0", in_m, scr_valid); end
  endtask

  task automatic test_ram_rw;
    drive_cycle(15'h0005, 16'h1234, 1'b1, 16'h0, 1'b0);
    drive_cycle(15'h0005, 16'h0000, 1'b0, 16'h0, 1'b0);
    n_cmp++; if (in_m !== 16'h1234) begin n_fail++; $display("FAIL ram_read: got %h expected 1234", in_m); end
    drive_cycle(15'h3FFF, 16'h5A5A, 1'b1, 16'h0, 1'b0);
    drive_cycle(15'h0005, 16'h0000, 1'b0, 16'h0, 1'b0);
    n_cmp++; if (in_m !== 16'h1234) begin n_fail++; $display("FAIL ram_other_addr: got %h expected 1234", in_m); end
    drive_cycle(15'h3FFF, 16'h0000, 1'b0, 16'h0, 1'b0);
    n_cmp++; if (in_m !== 16'h5A5A) begin n_fail++; $display("FAIL ram_top: got %h expected 5a5a", in_m); end
  endtask

  task automatic test_write_first;
    drive_cycle(15'h0010, 16'h1111, 1'b1, 16'h0, 1'b0);
    drive_cycle(15'h0010, 16'hBEEF, 1'b1, 16'h0, 1'b0);
    n_cmp++; if (in_m !== 16'hBEEF) begin n_fail++; $display("FAIL write_first: got %h expected beef", in_m); end
  endtask

  task automatic test_screen_single;
    drive_cycle(15'h4001, 16'hAAAA, 1'b1, 16'h0, 1'b1);
    n_cmp++; if (scr_valid !== 1'b1 || scr_addr !== 13'h0001 || scr_data !== 16'hAAAA) begin
      n_fail++; $display("FAIL screen_push: got v=%b a=%h d=%h expected 1/0001/aaaa", scr_valid, scr_addr, scr_data);
    end
    drive_cycle(15'h6001, 16'h0, 1'b0, 16'h0, 1'b1);
    n_cmp++; if (scr_valid !== 1'b0) begin n_fail++; $display("FAIL screen_pop: got v=%b expected 0", scr_valid); end
    drive_cycle(15'h4001, 16'h0, 1'b0, 16'h0, 1'b1);
    n_cmp++; if (in_m !== 16'hAAAA) begin n_fail++; $display("FAIL screen_shadow: got %h expected aaaa", in_m); end
  endtask

  task automatic test_keyboard;
    drive_cycle(15'h6000, 16'h0, 1'b0, 16'h0041, 1'b0);
    n_cmp++; if (in_m !== 16'h0041) begin n_fail++; $display("FAIL kbd_read: got %h expected 0041", in_m); end
    drive_cycle(15'h7000, 16'h0, 1'b0, 16'h0041, 1'b0);
    n_cmp++; if (in_m !== 16'h0000) begin n_fail++; $display("FAIL unmapped_read: got %h expected 0000", in_m); end
    drive_cycle(15'h6000, 16'h9999, 1'b1, 16'h0041, 1'b0);
    drive_cycle(15'h6000, 16'h0, 1'b0, 16'h0041, 1'b0);
    n_cmp++; if (in_m !== 16'h0041 || scr_valid !== 1'b0) begin
      n_fail++; $display("FAIL kbd_write_ignored: got %h v=%b expected 0041/0", in_m, scr_valid);
    end
    drive_cycle(15'h7000, 16'h7777, 1'b1, 16'h0041, 1'b0);
    drive_cycle(15'h7000, 16'h0, 1'b0, 16'h0041, 1'b0);
    n_cmp++; if (in_m !== 16'h0000 || scr_valid !== 1'b0) begin
      n_fail++; $display("FAIL unmapped_write_ignored: got %h v=%b expected 0000/0", in_m, scr_valid);
    end
  endtask

  task automatic test_fifo_full;
    for (int i = 0; i < DEPTH; i++) begin
      drive_cycle(15'h4010 + 15'(i), 16'hC000 + 16'(i), 1'b1, 16'h0, 1'b0);
      n_cmp++; if (scr_valid !== 1'b1 || scr_addr !== 13'h0010 || scr_data !== 16'hC000 || scr_ovf !== 1'b0) begin
        n_fail++; $display("FAIL fifo_fill_hold: got v=%b a=%h d=%h o=%b expected 1/0010/c000/0", scr_valid, scr_addr, scr_data, scr_ovf);
      end
    end
    drive_cycle(15'h4014, 16'hC004, 1'b1, 16'h0, 1'b1);
    n_cmp++; if (scr_ovf !== 1'b0 || scr_addr !== 13'h0011) begin
      n_fail++; $display("FAIL fifo_push_pop_full: got o=%b a=%h expected 0/0011", scr_ovf, scr_addr);
    end
    drive_cycle(15'h4015, 16'hC005, 1'b1, 16'h0, 1'b0);
    n_cmp++; if (scr_ovf !== 1'b1) begin n_fail++; $display("FAIL fifo_overflow: got %b expected 1", scr_ovf); end
    drive_cycle(15'h4015, 16'h0, 1'b0, 16'h0, 1'b0);
    n_cmp++; if (in_m !== 16'hC005) begin n_fail++; $display("FAIL overflow_shadow: got %h expected c005", in_m); end
    for (int i = 0; i < 8 && q.size() != 0; i++) begin
      n_cmp++; if (scr_valid !== 1'b1 || {scr_addr, scr_data} !== q[0]) begin
        n_fail++; $display("FAIL fifo_drain: got v=%b %h_%h expected 1 %h_%h", scr_valid, scr_addr, scr_data, q[0][28:16], q[0][15:0]);
      end
      drive_cycle(15'h6001, 16'h0, 1'b0, 16'h0, 1'b1);
    end
    n_cmp++; if (scr_valid !== 1'b0 || q.size() != 0) begin n_fail++; $display("FAIL fifo_empty: got v=%b expected 0", scr_valid); end
  endtask

  task automatic test_random;
    logic [14:0] pool [11];
    logic [14:0] a;
    pool = '{15'h0000, 15'h0007, 15'h3FFE, 15'h0100, 15'h4000, 15'h4003,
             15'h5FFF, 15'h4800, 15'h6000, 15'h6001, 15'h7FFF};
    for (int i = 0; i < 400; i++) begin
      a = pool[$urandom_range(10, 0)];
      drive_cycle(a, 16'($urandom), 1'($urandom_range(1, 0)), 16'($urandom), ($urandom_range(3, 0) == 0));
      if (exp_known) begin
        n_cmp++; if (in_m !== exp_in) begin n_fail++; $display("FAIL rand_in_m[%0d]: addr %h got %h expected %h", i, a, in_m, exp_in); end
      end
      n_cmp++;
      if (q.size() == 0) begin
        if (scr_valid !== 1'b0) begin n_fail++; $display("FAIL rand_valid[%0d]: got 1 expected 0", i); end
      end else if (scr_valid !== 1'b1 || {scr_addr, scr_data} !== q[0]) begin
        n_fail++; $display("FAIL rand_head[%0d]: got v=%b %h_%h expected 1 %h_%h", i, scr_valid, scr_addr, scr_data, q[0][28:16], q[0][15:0]);
      end
      n_cmp++; if (scr_ovf !== ovf_m) begin n_fail++; $display("FAIL rand_ovf[%0d]: got %b expected %b", i, scr_ovf, ovf_m); end
    end
  endtask

  task automatic test_reset_midburst;
    for (int i = 0; i < 20 && q.size() != 0; i++) drive_cycle(15'h6001, 16'h0, 1'b0, 16'h0, 1'b1);
    if (!ovf_m) begin
      for (int i = 0; i <= DEPTH; i++) drive_cycle(15'h4100 + 15'(i), 16'(i), 1'b1, 16'h0, 1'b0);
      for (int i = 0; i < 20 && q.size() != 0; i++) drive_cycle(15'h6001, 16'h0, 1'b0, 16'h0, 1'b1);
    end
    for (int i = 0; i < 3; i++) drive_cycle(15'h4200 + 15'(i), 16'hD000 + 16'(i), 1'b1, 16'h0, 1'b0);
    drive_cycle(15'h6000, 16'h0, 1'b0, 16'h0055, 1'b0);
    n_cmp++; if (scr_valid !== 1'b1 || scr_ovf !== 1'b1 || in_m !== 16'h0055) begin
      n_fail++; $display("FAIL pre_reset_state: got v=%b o=%b in=%h expected 1/1/0055", scr_valid, scr_ovf, in_m);
    end
    write_m = 1'b0;
    #2 resetN = 1'b0;
    #1;
    q.delete(); ovf_m = 1'b0;
    n_cmp++; if (scr_valid !== 1'b0 || scr_ovf !== 1'b0 || in_m !== 16'h0) begin
      n_fail++; $display("FAIL async_reset: got v=%b o=%b in=%h expected 0/0/0000", scr_valid, scr_ovf, in_m);
    end
    @(posedge clk); #1;
    resetN = 1'b1;
    #2;
    n_cmp++; if (scr_valid !== 1'b0 || in_m !== 16'h0) begin
      n_fail++; $display("FAIL reset_release: got v=%b in=%h expected 0/0000", scr_valid, in_m);
    end
    drive_cycle(15'h0005, 16'h0, 1'b0, 16'h0, 1'b0);
    n_cmp++; if (in_m !== 16'h1234 || scr_valid !== 1'b0) begin
      n_fail++; $display("FAIL ram_survives_reset: got %h v=%b expected 1234/0", in_m, scr_valid);
    end
  endtask

  initial begin
    test_reset();
    test_ram_rw();
    test_write_first();
    test_screen_single();
    test_keyboard();
    test_fifo_full();
    test_random();
    test_reset_midburst();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
